leaf_out_arbiter: RTL and testbench

Shares the leaf's single packet output toward the BFT between NUM_OUT_PORTS user output streams (valid/ack, PAYLOAD_BITS wide) and arbitrates among them round-robin. For each stream it adds the destination leaf/port from a runtime-written config table and a per-stream write address, then emits one PACKET_BITS packet. It tracks per-stream credits (free slots at the remote input BRAM) and refills them from freespace updates. It sits between the user-core outputs and the leaf's BFT-side output register.

---
 rtl/leaf_out_arbiter_if.sv | 35 +++
 rtl/leaf_out_arbiter.sv | 167 ++++++++++++++++
 tb/tb_leaf_out_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_out_arbiter_if.sv
// Bus bundle between the user output streams, the arbiter and the
// BFT-side output register.
//
// Handshake semantics:
//   user side : the core holds din_user[i]/vld_user[i] until it sees
//               ack_user[i] high in the same cycle; the beat transfers on
//               that clock edge. ack_user is one-hot or zero and is never
//               high without the matching vld_user.
//   pkt side  : pkt_out/pkt_vld are registered. While pkt_vld is high and
//               pkt_ack is low, pkt_out is held unchanged. pkt_ack high with
//               pkt_vld high consumes the packet on that edge.
interface leaf_out_arbiter_if #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_OUT_PORTS = 3
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user;
  logic [NUM_OUT_PORTS-1:0]              vld_user;
  logic [NUM_OUT_PORTS-1:0]              ack_user;
  logic [PACKET_BITS-1:0]                pkt_out;
  logic                                  pkt_vld;
  logic                                  pkt_ack;

  // User cores and the downstream register
  modport master (
    output din_user, vld_user, pkt_ack,
    input  ack_user, pkt_out, pkt_vld
  );

  // The arbiter
  modport slave (
    input  din_user, vld_user, pkt_ack,
    output ack_user, pkt_out, pkt_vld
  );
endinterface

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter that merges the user output streams onto the leaf's
// single packet output. Each stream gets its destination from a runtime
// config table, a free-running write address and a credit count that
// tracks free slots at the remote input BRAM.
module leaf_out_arbiter #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS = 3
) (
  input  logic                     clk,
  input  logic                     ap_rst_n,
  leaf_out_arbiter_if.slave        bus,
  input  logic                     cfg_wr,
  input  logic [2:0]               cfg_idx,
  input  logic [NUM_LEAF_BITS-1:0] cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_port,
  input  logic                     fs_vld,
  input  logic [2:0]               fs_idx,
  input  logic [NUM_ADDR_BITS:0]   fs_amt,
  output logic                     credit_err
);

  localparam int RR_W   = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CRED_W = NUM_ADDR_BITS + 1;
  // Credit ceiling: the remote BRAM depth.
  localparam logic [CRED_W-1:0] CRED_INIT = {1'b1, {NUM_ADDR_BITS{1'b0}}};
  localparam logic [CRED_W+1:0] CRED_CAP  = {2'b00, CRED_INIT};

  logic [NUM_LEAF_BITS-1:0] cfg_leaf_q  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] cfg_port_q  [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] cfg_valid_q;
  logic [NUM_ADDR_BITS-1:0] addr_q      [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit_q    [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit_d    [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] credit_ovf;
  logic [RR_W-1:0]          rr_q;

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic [RR_W-1:0]          grant_idx;
  logic                     any_grant;
  logic                     slot_free;

  logic [PAYLOAD_BITS-1:0]  sel_payload;
  logic [NUM_LEAF_BITS-1:0] sel_leaf;
  logic [NUM_PORT_BITS-1:0] sel_port;
  logic [NUM_ADDR_BITS-1:0] sel_addr;
  logic [PACKET_BITS-1:0]   pkt_d;

  // Round-robin pick: first eligible stream at or above rr, else wrap to the lowest eligible one
  always_comb begin
    slot_free = !bus.pkt_vld || bus.pkt_ack;
    eligible  = '0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = bus.vld_user[i] && cfg_valid_q[i] && (credit_q[i] != '0);
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (slot_free && !any_grant && eligible[i] && (RR_W'(i) >= rr_q)) begin
        any_grant = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = RR_W'(i);
      end
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (slot_free && !any_grant && eligible[i]) begin
        any_grant = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = RR_W'(i);
      end
    end
  end

  assign bus.ack_user = grant;

  // Mux the granted stream's fields into the next packet
  always_comb begin
    sel_payload = '0;
    sel_leaf    = '0;
    sel_port    = '0;
    sel_addr    = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant[i]) begin
        sel_payload = bus.din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        sel_leaf    = cfg_leaf_q[i];
        sel_port    = cfg_port_q[i];
        sel_addr    = addr_q[i];
      end
    end
  end

  assign pkt_d = {1'b1, sel_leaf, sel_port, sel_addr, sel_payload};

  // Net credit change per stream: refill plus grant in the same cycle, capped at the BRAM depth
  always_comb begin
    logic [CRED_W+1:0] sum;
    sum        = '0;
    credit_ovf = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = {2'b00, credit_q[i]}
          + ((fs_vld && (fs_idx == 3'(i))) ? {1'b0, fs_amt} : '0)
          - {{(CRED_W+1){1'b0}}, grant[i]};
      if (sum > CRED_CAP) begin
        credit_d[i]   = CRED_INIT;
        credit_ovf[i] = 1'b1;
      end else begin
        credit_d[i] = sum[CRED_W-1:0];
      end
    end
  end

  // Output packet register: load on grant, clear when the slot empties with no grant, else hold
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      bus.pkt_out <= '0;
      bus.pkt_vld <= 1'b0;
    end else if (any_grant) begin
      bus.pkt_out <= pkt_d;
      bus.pkt_vld <= 1'b1;
    end else if (slot_free) begin
      bus.pkt_out <= '0;
      bus.pkt_vld <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the last granted stream
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_q <= '0;
    end else if (any_grant) begin
      rr_q <= (grant_idx == RR_W'(NUM_OUT_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Per-stream config table, write address and credit counters
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cfg_valid_q <= '0;
      credit_err  <= 1'b0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        cfg_leaf_q[i] <= '0;
        cfg_port_q[i] <= '0;
        addr_q[i]     <= '0;
        credit_q[i]   <= CRED_INIT;
      end
    end else begin
      credit_err <= credit_err | (|credit_ovf);
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (cfg_wr && (cfg_idx == 3'(i))) begin
          cfg_leaf_q[i]  <= cfg_leaf;
          cfg_port_q[i]  <= cfg_port;
          cfg_valid_q[i] <= 1'b1;
        end
        if (grant[i]) begin
          addr_q[i] <= addr_q[i] + 1'b1;
        end
        credit_q[i] <= credit_d[i];
      end
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed plus randomized bench for leaf_out_arbiter. A behavioural model
// (integer credits/addresses, modulo round-robin) predicts ack_user before
// each edge and pkt_out/pkt_vld/credit_err after it.
module tb_leaf_out_arbiter;

  localparam int NP = 3;

  logic       clk = 1'b0;
  logic       ap_rst_n = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [4:0] cfg_leaf = '0;
  logic [3:0] cfg_port = '0;
  logic       fs_vld = 1'b0;
  logic [2:0] fs_idx = '0;
  logic [7:0] fs_amt = '0;
  logic       credit_err;

  leaf_out_arbiter_if #(.PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_OUT_PORTS(NP)) bus ();

  leaf_out_arbiter #(
    .PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5),
    .NUM_PORT_BITS(4), .NUM_ADDR_BITS(7), .NUM_OUT_PORTS(NP)
  ) dut (
    .clk(clk), .ap_rst_n(ap_rst_n), .bus(bus.slave),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_leaf(cfg_leaf), .cfg_port(cfg_port),
    .fs_vld(fs_vld), .fs_idx(fs_idx), .fs_amt(fs_amt),
    .credit_err(credit_err)
  );

  // Clock
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          m_cred [NP];
  int          m_addr [NP];
  logic [4:0]  m_leaf [NP];
  logic [3:0]  m_port [NP];
  bit          m_cv   [NP];
  int          m_rr;
  logic [48:0] m_pkt;
  bit          m_vld;
  bit          m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_cred[i] = 128; m_addr[i] = 0; m_leaf[i] = '0; m_port[i] = '0; m_cv[i] = 0;
    end
    m_rr = 0; m_pkt = '0; m_vld = 0; m_err = 0;
  endtask

  function automatic int model_pick();
    int j;
    if (m_vld && !bus.pkt_ack) return -1;
    for (int k = 0; k < NP; k++) begin
      j = (m_rr + k) % NP;
      if (bus.vld_user[j] && m_cv[j] && m_cred[j] > 0) return j;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    int c;
    if (g >= 0) begin
      m_pkt = {1'b1, m_leaf[g], m_port[g], 7'(m_addr[g]), bus.din_user[g*32 +: 32]};
      m_vld = 1;
      m_addr[g] = (m_addr[g] + 1) % 128;
      m_rr = (g + 1) % NP;
    end else if (!m_vld || bus.pkt_ack) begin
      m_pkt = '0;
      m_vld = 0;
    end
    for (int i = 0; i < NP; i++) begin
      c = m_cred[i];
      if (fs_vld && int'(fs_idx) == i) c += int'(fs_amt);
      if (g == i) c -= 1;
      if (c > 128) begin c = 128; m_err = 1; end
      m_cred[i] = c;
    end
    if (cfg_wr && int'(cfg_idx) < NP) begin
      m_leaf[cfg_idx] = cfg_leaf;
      m_port[cfg_idx] = cfg_port;
      m_cv[cfg_idx]   = 1;
    end
  endtask

  // One clock cycle: inputs were set at the preceding negedge
  int last_ack;
  task automatic step();
    int g;
    logic [2:0] ack_exp;
    #1;
    g = model_pick();
    ack_exp = (g >= 0) ? 3'(1 << g) : 3'b000;
    last_ack = int'(bus.ack_user);
    check("ack_user", 64'(bus.ack_user), 64'(ack_exp));
    @(posedge clk);
    model_update(g);
    #1;
    check("pkt_vld", 64'(bus.pkt_vld), 64'(m_vld));
    check("pkt_out", 64'(bus.pkt_out), 64'(m_pkt));
    check("credit_err", 64'(credit_err), 64'(m_err));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cfg_wr = 0; fs_vld = 0; bus.vld_user = '0; bus.pkt_ack = 1'b1;
  endtask

  task automatic cfg_write(input int idx, input logic [4:0] leaf, input logic [3:0] port);
    cfg_wr = 1; cfg_idx = 3'(idx); cfg_leaf = leaf; cfg_port = port;
    step();
    cfg_wr = 0;
  endtask

  task automatic rand_din();
    for (int i = 0; i < NP; i++) bus.din_user[i*32 +: 32] = $urandom;
  endtask

  initial begin
    int n;
    int cnt;
    bus.din_user = '0; bus.vld_user = '0; bus.pkt_ack = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_pkt_vld", 64'(bus.pkt_vld), 64'd0);
    check("rst_pkt_out", 64'(bus.pkt_out), 64'd0);
    check("rst_ack", 64'(bus.ack_user), 64'd0);
    check("rst_credit_err", 64'(credit_err), 64'd0);
    @(negedge clk);
    ap_rst_n = 1;
    idle_inputs();
    @(negedge clk);

    // Single packet from stream 0
    cfg_write(0, 5'd3, 4'd2);
    bus.din_user[31:0] = 32'hDEADBEEF;
    bus.vld_user = 3'b001;
    step();
    check("first_ack", 64'(last_ack), 64'd1);
    check("first_pkt", 64'(bus.pkt_out), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));
    bus.vld_user = '0;
    step();

    // All three streams contend at full throughput
    cfg_write(1, 5'($urandom), 4'($urandom));
    cfg_write(2, 5'($urandom), 4'($urandom));
    bus.vld_user = 3'b111;
    for (int i = 0; i < 6; i++) begin
      rand_din();
      step();
    end

    // Downstream stall: hold packet, no grants; release grants in the same cycle
    bus.pkt_ack = 0;
    for (int i = 0; i < 4; i++) begin
      rand_din();
      step();
      check("stall_no_ack", 64'(last_ack), 64'd0);
    end
    bus.pkt_ack = 1;
    step();

    // Exhaust stream 1 credits, then refill
    bus.vld_user = 3'b010;
    n = 0;
    while (m_cred[1] != 0 && n < 300) begin
      rand_din();
      step();
      n++;
    end
    check("drain1_bound", 64'(n < 300), 64'd1);
    bus.vld_user = 3'b111;
    for (int i = 0; i < 4; i++) begin
      rand_din();
      step();
      check("s1_no_credit", 64'(last_ack & 2), 64'd0);
    end
    bus.vld_user = 3'b010;
    fs_vld = 1; fs_idx = 3'd1; fs_amt = 8'd64;
    step();
    fs_vld = 0;
    rand_din();
    step();
    check("s1_resume_ack", 64'(last_ack), 64'd2);
    check("s1_addr_wrap", 64'(bus.pkt_out[38:32]), 64'd0);

    // Reset while a packet is being held
    bus.vld_user = 3'b001;
    step();
    bus.pkt_ack = 0;
    ap_rst_n = 0;
    #1;
    check("midrst_pkt_vld", 64'(bus.pkt_vld), 64'd0);
    check("midrst_pkt_out", 64'(bus.pkt_out), 64'd0);
    model_reset();
    @(negedge clk);
    ap_rst_n = 1;
    idle_inputs();
    @(negedge clk);

    // Unconfigured stream is never acked until configured
    bus.vld_user = 3'b100;
    for (int i = 0; i < 3; i++) begin
      rand_din();
      step();
      check("uncfg_no_ack", 64'(last_ack), 64'd0);
    end
    cfg_write(2, 5'd17, 4'd9);
    check("cfg_cycle_no_ack", 64'(last_ack), 64'd0);
    step();
    check("cfg_next_ack", 64'(last_ack), 64'd4);
    bus.vld_user = '0;

    // Out-of-range freespace index is ignored; overflow sets sticky error
    fs_vld = 1; fs_idx = 3'd5; fs_amt = 8'd200;
    step();
    cfg_write(0, 5'd1, 4'd1);
    fs_vld = 1; fs_idx = 3'd0; fs_amt = 8'd10;
    step();
    fs_vld = 0;
    check("credit_err_set", 64'(credit_err), 64'd1);

    // Grant and refill in one cycle: 5 + 3 - 1 = 7 remaining grants
    bus.vld_user = 3'b001;
    n = 0;
    while (m_cred[0] != 5 && n < 300) begin
      rand_din();
      step();
      n++;
    end
    check("drain0_bound", 64'(n < 300), 64'd1);
    fs_vld = 1; fs_idx = 3'd0; fs_amt = 8'd3;
    step();
    fs_vld = 0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      rand_din();
      step();
      if (last_ack == 1) cnt++;
    end
    check("net_credit_grants", 64'(cnt), 64'd7);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_din();
      bus.vld_user = 3'($urandom);
      bus.pkt_ack  = ($urandom_range(0, 3) != 0);
      cfg_wr   = ($urandom_range(0, 9) == 0);
      cfg_idx  = 3'($urandom_range(0, 4));
      cfg_leaf = 5'($urandom);
      cfg_port = 4'($urandom);
      fs_vld   = ($urandom_range(0, 3) == 0);
      fs_idx   = 3'($urandom_range(0, 4));
      fs_amt   = 8'($urandom_range(0, 12));
      step();
    end
    idle_inputs();
    step();

    // Sticky error clears only on reset
    ap_rst_n = 0;
    #1;
    check("final_rst_err", 64'(credit_err), 64'd0);
    check("final_rst_vld", 64'(bus.pkt_vld), 64'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
